// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, request/ack fetch FSM, IF/ID register and one-entry
// hold buffer that absorbs decode back-pressure; execute redirects take top priority.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        InstrValid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] instr_pc_r, instr_pc_s;
  logic        instr_valid_r, instr_valid_s;
  logic [31:0] hold_data_r, hold_data_s;
  logic [31:0] hold_pc_r, hold_pc_s;
  logic        accept_s;
  logic [31:0] redirect_target_s;

  assign accept_s          = !instr_valid_r || !Stall;
  assign redirect_target_s = RedirectPC & 32'hFFFF_FFFC;

  assign IMemReq    = (state_r == FETCH);
  assign IMemAddr   = pc_r;
  assign Instr      = instr_r;
  assign InstrPC    = instr_pc_r;
  assign InstrValid = instr_valid_r;

  // Next-state, next-PC and IF/ID / hold-buffer load decisions.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    instr_s       = instr_r;
    instr_pc_s    = instr_pc_r;
    instr_valid_s = instr_valid_r;
    hold_data_s   = hold_data_r;
    hold_pc_s     = hold_pc_r;

    case (state_r)
      IDLE: begin
        state_s = FETCH;
        if (Redirect) begin
          pc_s = redirect_target_s;
        end else begin
          pc_s = pc_r;
        end
        if (accept_s) begin
          instr_valid_s = 1'b0;
        end else begin
          instr_valid_s = instr_valid_r;
        end
      end

      FETCH: begin
        if (Redirect) begin
          // Redirect discards any acknowledged word and wins over a stall.
          pc_s          = redirect_target_s;
          instr_valid_s = 1'b0;
          hold_data_s   = 32'h0000_0000;
          hold_pc_s     = 32'h0000_0000;
          state_s       = FETCH;
        end else if (IMemAck) begin
          pc_s = pc_r + 32'd4;
          if (accept_s) begin
            instr_s       = IMemData;
            instr_pc_s    = pc_r;
            instr_valid_s = 1'b1;
            state_s       = FETCH;
          end else begin
            hold_data_s = IMemData;
            hold_pc_s   = pc_r;
            state_s     = HOLD;
          end
        end else if (accept_s) begin
          instr_valid_s = 1'b0;
        end else begin
          instr_valid_s = instr_valid_r;
        end
      end

      HOLD: begin
        if (Redirect) begin
          pc_s          = redirect_target_s;
          instr_valid_s = 1'b0;
          hold_data_s   = 32'h0000_0000;
          hold_pc_s     = 32'h0000_0000;
          state_s       = FETCH;
        end else if (accept_s) begin
          instr_s       = hold_data_r;
          instr_pc_s    = hold_pc_r;
          instr_valid_s = 1'b1;
          state_s       = FETCH;
        end else begin
          state_s = HOLD;
        end
      end

      default: begin
        state_s       = IDLE;
        instr_valid_s = 1'b0;
      end
    endcase
  end

  // State, PC, IF/ID and hold-buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC_ALIGNED;
      instr_r       <= NOP_INSTR;
      instr_pc_r    <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      hold_data_r   <= 32'h0000_0000;
      hold_pc_r     <= 32'h0000_0000;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      instr_r       <= instr_s;
      instr_pc_r    <= instr_pc_s;
      instr_valid_r <= instr_valid_s;
      hold_data_r   <= hold_data_s;
      hold_pc_r     <= hold_pc_s;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns its own address as instruction data.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req_s;
  logic [31:0] imem_addr_s;
  logic        imem_ack_r;
  logic [31:0] imem_data_s;
  logic        stall_r;
  logic        redirect_r;
  logic [31:0] redirect_pc_r;
  logic [31:0] instr_s;
  logic [31:0] instr_pc_s;
  logic        instr_valid_s;

  int total_cnt = 0;
  int bad_cnt   = 0;

  assign imem_data_s = imem_addr_s;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk       (clk),
    .rst       (rst),
    .IMemReq   (imem_req_s),
    .IMemAddr  (imem_addr_s),
    .IMemAck   (imem_ack_r),
    .IMemData  (imem_data_s),
    .Stall     (stall_r),
    .Redirect  (redirect_r),
    .RedirectPC(redirect_pc_r),
    .Instr     (instr_s),
    .InstrPC   (instr_pc_s),
    .InstrValid(instr_valid_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic [31:0] ins, input logic [31:0] ipc, input logic vld);
    check_val({tag, "_instr"}, instr_s, ins);
    check_val({tag, "_ipc"}, instr_pc_s, ipc);
    check_val({tag, "_valid"}, {31'd0, instr_valid_s}, {31'd0, vld});
  endtask

  task automatic check_mem(input string tag, input logic req, input logic [31:0] addr);
    check_val({tag, "_req"}, {31'd0, imem_req_s}, {31'd0, req});
    check_val({tag, "_addr"}, imem_addr_s, addr);
  endtask

  initial begin
    rst           = 1'b1;
    imem_ack_r    = 1'b1;
    stall_r       = 1'b0;
    redirect_r    = 1'b0;
    redirect_pc_r = 32'h0000_0000;
    #3;
    check_if("rst", 32'h0000_0013, 32'h0000_0000, 1'b0);
    check_mem("rst", 1'b0, 32'h0000_0100);
    #9 rst = 1'b0;

    // edge 1: IDLE -> FETCH
    step();
    check_mem("idle_out", 1'b1, 32'h0000_0100);
    check_val("idle_out_valid", {31'd0, instr_valid_s}, 32'd0);
    // zero-wait stream
    step(); check_if("s100", 32'h0000_0100, 32'h0000_0100, 1'b1);
    step(); check_if("s104", 32'h0000_0104, 32'h0000_0104, 1'b1);
    step(); check_if("s108", 32'h0000_0108, 32'h0000_0108, 1'b1);
    check_mem("s108", 1'b1, 32'h0000_010C);
    imem_ack_r = 1'b0;

    // ack for 0x10C delayed 3 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("wait_valid", {31'd0, instr_valid_s}, 32'd0);
      check_mem("wait", 1'b1, 32'h0000_010C);
    end
    imem_ack_r = 1'b1;
    step(); check_if("s10c", 32'h0000_010C, 32'h0000_010C, 1'b1);
    check_mem("s10c", 1'b1, 32'h0000_0110);

    // stall two cycles: 0x110 goes to the hold buffer
    stall_r = 1'b1;
    step(); check_if("hold1", 32'h0000_010C, 32'h0000_010C, 1'b1);
    check_mem("hold1", 1'b0, 32'h0000_0114);
    step(); check_if("hold2", 32'h0000_010C, 32'h0000_010C, 1'b1);
    check_mem("hold2", 1'b0, 32'h0000_0114);
    stall_r = 1'b0;
    step(); check_if("unhold", 32'h0000_0110, 32'h0000_0110, 1'b1);
    check_mem("unhold", 1'b1, 32'h0000_0114);
    step(); check_if("s114", 32'h0000_0114, 32'h0000_0114, 1'b1);

    // redirect while stalled in HOLD with ack high
    stall_r = 1'b1;
    step(); check_mem("hold3", 1'b0, 32'h0000_011C);
    redirect_r    = 1'b1;
    redirect_pc_r = 32'h0000_0203;
    step(); check_val("redir_valid", {31'd0, instr_valid_s}, 32'd0);
    check_mem("redir", 1'b1, 32'h0000_0200);
    redirect_r = 1'b0;
    stall_r    = 1'b0;
    step(); check_if("s200", 32'h0000_0200, 32'h0000_0200, 1'b1);
    step(); check_if("s204", 32'h0000_0204, 32'h0000_0204, 1'b1);

    // PC wraparound
    redirect_r    = 1'b1;
    redirect_pc_r = 32'hFFFF_FFFC;
    step(); check_val("wrap_valid", {31'd0, instr_valid_s}, 32'd0);
    check_mem("wrap", 1'b1, 32'hFFFF_FFFC);
    redirect_r = 1'b0;
    step(); check_if("wfffc", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
    step(); check_if("w0000", 32'h0000_0000, 32'h0000_0000, 1'b1);
    step(); check_if("w0004", 32'h0000_0004, 32'h0000_0004, 1'b1);

    // asynchronous reset while in HOLD
    stall_r = 1'b1;
    step(); check_mem("hold4", 1'b0, 32'h0000_000C);
    #2 rst = 1'b1;
    #1;
    check_if("arst", 32'h0000_0013, 32'h0000_0000, 1'b0);
    check_mem("arst", 1'b0, 32'h0000_0100);

    // redirect during the IDLE cycle
    #2;
    rst           = 1'b0;
    stall_r       = 1'b0;
    redirect_r    = 1'b1;
    redirect_pc_r = 32'h0000_0301;
    step(); check_mem("idle_redir", 1'b1, 32'h0000_0300);
    redirect_r = 1'b0;
    step(); check_if("s300", 32'h0000_0300, 32'h0000_0300, 1'b1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
